// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-access stage: funct3 access codes,
// FSM state encoding and timeout counter sizing.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Counter is sized for the largest legal TIMEOUT so any setting fits.
    localparam int TIMEOUT_MAX = 65535;
    localparam int TO_CNT_W    = $clog2(TIMEOUT_MAX + 1);

    // Doubleword and WU encodings only exist on a 64-bit bus; stores have no unsigned forms.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_load, input logic dw64);
        if (is_load)
            return (f3 != 3'b111) && (dw64 || ((f3 != F3_D) && (f3 != F3_WU)));
        else
            return !f3[2] && (dw64 || (f3 != F3_D));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-side lane select and sign/zero extension of a raw memory word.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]           rdata,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
    input  logic [2:0]                      funct3,
    output logic [DATA_WIDTH-1:0]           data
);

    logic [DATA_WIDTH-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = DATA_WIDTH'($signed(shifted[7:0]));
            F3_H:    data = DATA_WIDTH'($signed(shifted[15:0]));
            F3_W:    data = DATA_WIDTH'($signed(shifted[31:0]));
            F3_D:    data = shifted;
            F3_BU:   data = DATA_WIDTH'(shifted[7:0]);
            F3_HU:   data = DATA_WIDTH'(shifted[15:0]);
            F3_WU:   data = DATA_WIDTH'(shifted[31:0]);
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage load/store unit: issues one request per access over a
// req/rvalid bus, stalls the pipeline while waiting, and bounds the wait with a timeout.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    MemReadM,
    input  logic                    MemWriteM,
    input  logic [2:0]              funct3M,
    input  logic [ADDR_WIDTH-1:0]   ALUResultM,
    input  logic [DATA_WIDTH-1:0]   WriteDataM,
    output logic [DATA_WIDTH-1:0]   ReadDataM,
    output logic                    StallM,
    output logic                    misaligned,
    output logic                    bus_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_rvalid
);

    localparam int   NB    = DATA_WIDTH / 8;
    localparam int   OFF_W = $clog2(NB);
    localparam logic DW64  = (DATA_WIDTH == 64);

    lsu_state_e            state_reg, state_next;
    logic [TO_CNT_W-1:0]   cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [OFF_W-1:0]      off_reg, off_next;
    logic [2:0]            f3_reg, f3_next;

    logic                  access, is_load, legal, aligned;
    logic [1:0]            size_log2;
    logic [OFF_W-1:0]      offset, size_mask;
    logic [NB-1:0]         be_base;
    logic [DATA_WIDTH-1:0] wdata_rep, load_data;

    assign access    = MemReadM | MemWriteM;
    assign is_load   = MemReadM;
    assign size_log2 = funct3M[1:0];
    assign offset    = ALUResultM[OFF_W-1:0];
    assign legal     = f3_legal(funct3M, is_load, DW64);

    always_comb begin
        size_mask = '0;
        be_base   = '0;
        case (size_log2)
            2'd0: begin size_mask = '0;           be_base = NB'(4'b0001); end
            2'd1: begin size_mask = OFF_W'(1);    be_base = NB'(4'b0011); end
            2'd2: begin size_mask = OFF_W'(3);    be_base = NB'(4'b1111); end
            default: begin size_mask = OFF_W'(7); be_base = '1;           end
        endcase
    end

    assign aligned = legal && ((offset & size_mask) == '0);

    // Each lane repeats the low bytes of the store data at the access size.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_byte;
            always_comb begin
                lane_byte = '0;
                case (size_log2)
                    2'd0:    lane_byte = WriteDataM[7:0];
                    2'd1:    lane_byte = WriteDataM[(gi % 2) * 8 +: 8];
                    2'd2:    lane_byte = WriteDataM[(gi % 4) * 8 +: 8];
                    default: lane_byte = WriteDataM[gi * 8 +: 8];
                endcase
            end
            assign wdata_rep[gi * 8 +: 8] = lane_byte;
        end
    endgenerate

    // Offset and size are latched at issue so the response is aligned independent of the M inputs.
    lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .rdata  (mem_rdata),
        .offset (off_reg),
        .funct3 (f3_reg),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            data_reg  <= '0;
            off_reg   <= '0;
            f3_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            off_reg   <= off_next;
            f3_reg    <= f3_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        off_next   = off_reg;
        f3_next    = f3_reg;
        ReadDataM  = '0;
        StallM     = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (access) begin
                    if (aligned) begin
                        mem_req    = 1'b1;
                        mem_we     = !is_load;
                        mem_be     = be_base << offset;
                        mem_addr   = {ALUResultM[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        mem_wdata  = is_load ? '0 : wdata_rep;
                        StallM     = 1'b1;
                        off_next   = offset;
                        f3_next    = funct3M;
                        state_next = ST_WAIT;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                StallM = 1'b1;
                if (mem_rvalid) begin
                    data_next  = load_data;
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end else if (cnt_reg == TO_CNT_W'(TIMEOUT - 1)) begin
                    bus_err    = 1'b1;
                    data_next  = '0;
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                ReadDataM  = data_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomised and directed bench for lsu_mem_stage: a 32-bit and a 64-bit
// instance share stimulus, and a per-cycle expectation from a transaction-level model.
module tb_lsu_mem_stage;

    localparam int TO_A = 6;
    localparam int TO_B = 4;

    typedef struct packed {
        logic        req;
        logic        we;
        logic        stall;
        logic        mis;
        logic        berr;
        logic [7:0]  be;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } obs_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sel;
    logic        t_rd, t_wr, t_rvalid;
    logic [2:0]  t_f3;
    logic [31:0] t_addr;
    logic [63:0] t_wdata, t_rdata;
    obs_t        exp_o;
    bit          chk_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_req = 0, n_stall = 0, n_mis = 0, n_berr = 0;

    logic [31:0] rd_a, wd_a;
    logic        st_a, mis_a, be_err_a, req_a, we_a;
    logic [3:0]  be_a;
    logic [31:0] addr_a;
    logic [63:0] rd_b, wd_b;
    logic        st_b, mis_b, be_err_b, req_b, we_b;
    logic [7:0]  be_b;
    logic [31:0] addr_b;

    always #5 clk = ~clk;

    lsu_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .resetn(resetn),
        .MemReadM(t_rd & ~sel), .MemWriteM(t_wr & ~sel), .funct3M(t_f3),
        .ALUResultM(t_addr), .WriteDataM(t_wdata[31:0]),
        .ReadDataM(rd_a), .StallM(st_a), .misaligned(mis_a), .bus_err(be_err_a),
        .mem_req(req_a), .mem_we(we_a), .mem_be(be_a), .mem_addr(addr_a), .mem_wdata(wd_a),
        .mem_rdata(t_rdata[31:0]), .mem_rvalid(t_rvalid)
    );

    lsu_mem_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .resetn(resetn),
        .MemReadM(t_rd & sel), .MemWriteM(t_wr & sel), .funct3M(t_f3),
        .ALUResultM(t_addr), .WriteDataM(t_wdata),
        .ReadDataM(rd_b), .StallM(st_b), .misaligned(mis_b), .bus_err(be_err_b),
        .mem_req(req_b), .mem_we(we_b), .mem_be(be_b), .mem_addr(addr_b), .mem_wdata(wd_b),
        .mem_rdata(t_rdata), .mem_rvalid(t_rvalid)
    );

    // ---------------- reference model ----------------
    function automatic bit m_legal(logic [2:0] f3, bit ld, int dw);
        if (ld) return !(f3 == 3'd7 || (dw == 32 && (f3 == 3'd3 || f3 == 3'd6)));
        return (f3 <= 3'd3) && !(dw == 32 && f3 == 3'd3);
    endfunction

    function automatic int m_nb(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [7:0] m_be(logic [2:0] f3, logic [31:0] addr, int dw);
        int lane = int'(addr % (dw / 8));
        return 8'(((1 << m_nb(f3)) - 1) << lane);
    endfunction

    function automatic logic [63:0] m_wdata(logic [2:0] f3, logic [63:0] wd, int dw);
        logic [63:0] r = '0;
        int nb = m_nb(f3);
        for (int i = 0; i < dw / 8; i++) r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_load(logic [63:0] rdata, logic [31:0] addr, logic [2:0] f3, int dw);
        logic [63:0] raw, v, mask;
        int nb = m_nb(f3);
        int lane = int'(addr % (dw / 8));
        if (dw == 32) rdata = rdata & 64'hFFFF_FFFF;
        raw = rdata >> (8 * lane);
        if (nb == 8) begin
            v = raw;
        end else begin
            mask = (64'd1 << (8 * nb)) - 64'd1;
            v = raw & mask;
            if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        end
        if (dw == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_obs(input string who, input obs_t a, input obs_t e);
        chk({who, ".req"},   64'(a.req),   64'(e.req));
        chk({who, ".we"},    64'(a.we),    64'(e.we));
        chk({who, ".stall"}, 64'(a.stall), 64'(e.stall));
        chk({who, ".mis"},   64'(a.mis),   64'(e.mis));
        chk({who, ".berr"},  64'(a.berr),  64'(e.berr));
        chk({who, ".be"},    64'(a.be),    64'(e.be));
        chk({who, ".addr"},  64'(a.addr),  64'(e.addr));
        chk({who, ".wdata"}, a.wdata,      e.wdata);
        chk({who, ".rdata"}, a.rdata,      e.rdata);
    endtask

    always @(negedge clk) begin
        obs_t oa, ob, ea, eb;
        if (chk_en) begin
            oa = '{req: req_a, we: we_a, stall: st_a, mis: mis_a, berr: be_err_a,
                   be: {4'b0, be_a}, addr: addr_a, wdata: {32'b0, wd_a}, rdata: {32'b0, rd_a}};
            ob = '{req: req_b, we: we_b, stall: st_b, mis: mis_b, berr: be_err_b,
                   be: be_b, addr: addr_b, wdata: wd_b, rdata: rd_b};
            ea = sel ? obs_t'('0) : exp_o;
            eb = sel ? exp_o : obs_t'('0);
            cmp_obs("A", oa, ea);
            cmp_obs("B", ob, eb);
            if (sel ? req_b : req_a) n_req++;
            if (sel ? st_b : st_a) n_stall++;
            if (sel ? mis_b : mis_a) n_mis++;
            if (sel ? be_err_b : be_err_a) n_berr++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // lat = number of WAIT cycles before rvalid (0 = first WAIT cycle); -1 = never.
    task automatic run_access(input bit s, input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [63:0] wd,
                              input logic [63:0] rv_data, input int lat,
                              output logic [63:0] result);
        int dw = s ? 64 : 32;
        int to = s ? TO_B : TO_A;
        bit ld = rd;
        result = '0;
        sel = s; t_rd = rd; t_wr = wr; t_f3 = f3; t_addr = addr; t_wdata = wd;
        t_rvalid = ($urandom % 4 == 0); t_rdata = rnd64();
        exp_o = '0;
        if (!(rd || wr)) begin
            step();
            return;
        end
        if (!m_legal(f3, ld, dw) || (addr % m_nb(f3)) != 0) begin
            exp_o.mis = 1'b1;
            step();
        end else begin
            exp_o.req   = 1'b1;
            exp_o.we    = !ld;
            exp_o.be    = m_be(f3, addr, dw);
            exp_o.addr  = addr & ~32'(dw / 8 - 1);
            exp_o.wdata = ld ? 64'd0 : m_wdata(f3, wd, dw);
            exp_o.stall = 1'b1;
            step();
            for (int k = 0; k < to; k++) begin
                exp_o = '0;
                exp_o.stall = 1'b1;
                t_rvalid = (k == lat);
                t_rdata  = (k == lat) ? rv_data : rnd64();
                if (k == lat) begin
                    result = m_load(rv_data, addr, f3, dw);
                    step();
                    break;
                end
                if (k == to - 1) exp_o.berr = 1'b1;
                step();
            end
            exp_o = '0;
            exp_o.rdata = result;
            t_rvalid = $urandom % 2;
            t_rdata  = rnd64();
            step();
        end
        exp_o = '0;
        t_rd = 1'b0; t_wr = 1'b0; t_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        int s0, r0, m0, b0;
        resetn = 1'b0; sel = 1'b0; t_rd = 1'b0; t_wr = 1'b0; t_f3 = '0;
        t_addr = '0; t_wdata = '0; t_rdata = '0; t_rvalid = 1'b0; exp_o = '0;
        chk_en = 1'b1;
        step(); step();
        resetn = 1'b1;
        step();

        // Model pins against hand-computed values
        chk("pin_load_lb", m_load(64'h80FF_0000, 32'h103, 3'b000, 32), 64'hFFFF_FF80);
        chk("pin_be_lb",   64'(m_be(3'b000, 32'h103, 32)), 64'h8);
        chk("pin_be_sh",   64'(m_be(3'b001, 32'h202, 32)), 64'hC);
        chk("pin_wd_sh",   m_wdata(3'b001, 64'h0000_BEEF, 32), 64'hBEEF_BEEF);
        chk("pin_be_lwu",  64'(m_be(3'b110, 32'h14, 64)), 64'hF0);
        chk("pin_load_lwu", m_load(64'hDEAD_BEEF_8000_0001, 32'h14, 3'b110, 64), 64'hDEAD_BEEF);

        // 1: LB at 0x103, rvalid in first WAIT cycle
        s0 = n_stall; r0 = n_req;
        run_access(1'b0, 1'b1, 1'b0, 3'b000, 32'h103, 64'h0, 64'h80FF_0000, 0, res);
        step();
        chk("t1_result", res, 64'hFFFF_FF80);
        chk("t1_stall_cycles", 64'(n_stall - s0), 64'd2);
        chk("t1_req_pulses", 64'(n_req - r0), 64'd1);

        // 2: SH at 0x202
        r0 = n_req;
        run_access(1'b0, 1'b0, 1'b1, 3'b001, 32'h202, 64'h0000_BEEF, 64'h1234_5678, 2, res);
        step();
        chk("t2_req_pulses", 64'(n_req - r0), 64'd1);

        // 3: misaligned LW at 0x101
        r0 = n_req; s0 = n_stall; m0 = n_mis;
        run_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h101, 64'h0, 64'h0, 0, res);
        step();
        chk("t3_req_pulses", 64'(n_req - r0), 64'd0);
        chk("t3_stall_cycles", 64'(n_stall - s0), 64'd0);
        chk("t3_mis_pulses", 64'(n_mis - m0), 64'd1);

        // 4: timeout on the TIMEOUT=4 instance
        b0 = n_berr; s0 = n_stall;
        run_access(1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 64'h0, 64'h0, -1, res);
        step();
        chk("t4_berr_pulses", 64'(n_berr - b0), 64'd1);
        chk("t4_stall_cycles", 64'(n_stall - s0), 64'd5);
        chk("t4_result", res, 64'd0);

        // 5: reset during WAIT, then a stray response
        sel = 1'b0; t_rd = 1'b1; t_f3 = 3'b010; t_addr = 32'h40;
        exp_o = '0; exp_o.req = 1'b1; exp_o.be = 8'hF; exp_o.addr = 32'h40; exp_o.stall = 1'b1;
        step();
        exp_o = '0; exp_o.stall = 1'b1;
        step();
        resetn = 1'b0; t_rd = 1'b0; exp_o = '0;
        step(); step();
        resetn = 1'b1; t_rvalid = 1'b1; t_rdata = 64'hCAFE_F00D_CAFE_F00D;
        step();
        t_rvalid = 1'b0;
        step();

        // 6: LWU at 0x14 on the 64-bit instance
        run_access(1'b1, 1'b1, 1'b0, 3'b110, 32'h14, 64'h0, 64'hDEAD_BEEF_8000_0001, 1, res);
        step();
        chk("t6_result", res, 64'h0000_0000_DEAD_BEEF);

        // Random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            bit s, rd, wr;
            logic [2:0] f3;
            logic [31:0] addr;
            int off, lat;
            s  = $urandom % 2;
            rd = ($urandom % 4) != 0;
            wr = $urandom % 2;
            f3 = 3'($urandom % 8);
            off = $urandom % 8;
            if ($urandom % 3 != 0) off = off & ~(m_nb(f3) - 1);
            addr = ($urandom & 32'hFFFF_FFF8) | 32'(off);
            lat = int'($urandom % 9) - 1;
            run_access(s, rd, wr, f3, addr, rnd64(), rnd64(), lat, res);
            if ($urandom % 4 == 0) begin
                t_rvalid = 1'b1; t_rdata = rnd64(); exp_o = '0;
                step();
                t_rvalid = 1'b0;
            end
        end
        step();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
